// File: rtl/alu_shift_unit.sv
// ALU / serial shifter with a single-entry valid/ready request and response.
// ALU ops finish in one cycle; shifts move one bit per cycle under a down-counter.
module alu_shift_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_kind,
   input  logic        req_invert_a,
   input  logic        req_invert_b,
   input  logic [1:0]  req_operation,
   input  logic        req_left_right,
   input  logic [4:0]  req_shamt,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_overflow
);

   typedef enum logic [1:0] {IDLE, ALU, SHIFT, DONE} state_e;

   state_e      state_q, state_d;
   logic        inv_a_q, inv_a_d;
   logic        inv_b_q, inv_b_d;
   logic [1:0]  op_q, op_d;
   logic        lr_q, lr_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] work_q, work_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        zero_q, zero_d;
   logic        ovf_q, ovf_d;

   logic [31:0] a_p, b_p;
   logic [32:0] sum;
   logic [33:0] diff;
   logic        add_ovf;
   logic [31:0] alu_res;

   always_comb begin
      a_p     = inv_a_q ? ~a_q : a_q;
      b_p     = inv_b_q ? ~b_q : b_q;
      sum     = {1'b0, a_p} + {1'b0, b_p} + {32'd0, inv_b_q};
      // carry into bit 31 recovered from the sum bit; overflow when it differs from carry out
      add_ovf = (a_p[31] ^ b_p[31] ^ sum[31]) ^ sum[32];
      // exact signed A' - (B' + cin) in 34 bits so the sign is never corrupted by wrap
      diff    = {{2{a_p[31]}}, a_p} - {{2{b_p[31]}}, b_p} - {33'd0, inv_b_q};
      case (op_q)
         2'b00:   alu_res = a_p & b_p;
         2'b01:   alu_res = a_p | b_p;
         2'b10:   alu_res = sum[31:0];
         default: alu_res = {31'd0, diff[33]};
      endcase
   end

   always_comb begin
      state_d  = state_q;
      inv_a_d  = inv_a_q;
      inv_b_d  = inv_b_q;
      op_d     = op_q;
      lr_d     = lr_q;
      a_d      = a_q;
      b_d      = b_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               inv_a_d = req_invert_a;
               inv_b_d = req_invert_b;
               op_d    = req_operation;
               lr_d    = req_left_right;
               a_d     = req_a;
               b_d     = req_b;
               work_d  = req_a;
               cnt_d   = req_shamt;
               state_d = req_kind ? SHIFT : ALU;
            end
         end
         ALU: begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = (op_q == 2'b10) & add_ovf;
            state_d  = DONE;
         end
         SHIFT: begin
            if (cnt_q == '0) begin
               result_d = work_q;
               zero_d   = (work_q == '0);
               ovf_d    = 1'b0;
               state_d  = DONE;
            end else begin
               work_d = lr_q ? {work_q[30:0], 1'b0} : {1'b0, work_q[31:1]};
               cnt_d  = cnt_q - 5'd1;
            end
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         inv_a_q  <= 1'b0;
         inv_b_q  <= 1'b0;
         op_q     <= '0;
         lr_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         work_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         inv_a_q  <= inv_a_d;
         inv_b_q  <= inv_b_d;
         op_q     <= op_d;
         lr_q     <= lr_d;
         a_q      <= a_d;
         b_q      <= b_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign rsp_valid    = (state_q == DONE);
   assign rsp_result   = result_q;
   assign rsp_zero     = zero_q;
   assign rsp_overflow = ovf_q;

endmodule

// File: tb/tb_alu_shift_unit.sv
// Directed-vector bench for alu_shift_unit: table of requests with hand-computed
// results, flags and latencies, plus back-pressure and mid-operation reset sequences.
module tb_alu_shift_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_kind, req_invert_a, req_invert_b;
   logic [1:0]  req_operation;
   logic        req_left_right;
   logic [4:0]  req_shamt;
   logic [31:0] req_a, req_b;
   logic        rsp_valid, rsp_ready, rsp_zero, rsp_overflow;
   logic [31:0] rsp_result;

   int n_checks = 0;
   int n_fail   = 0;

   alu_shift_unit dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_invert_a(req_invert_a), .req_invert_b(req_invert_b),
      .req_operation(req_operation), .req_left_right(req_left_right),
      .req_shamt(req_shamt), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        kind, inv_a, inv_b;
      logic [1:0]  op;
      logic        lr;
      logic [4:0]  shamt;
      logic [31:0] a, b;
      logic [31:0] res;
      logic        zero, ovf;
      int          lat;
   } vec_t;

   function automatic vec_t mk(input logic kind, input logic inv_a, input logic inv_b,
                               input logic [1:0] op, input logic lr, input logic [4:0] shamt,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic zero, input logic ovf,
                               input int lat);
      vec_t v;
      v.kind = kind; v.inv_a = inv_a; v.inv_b = inv_b; v.op = op; v.lr = lr;
      v.shamt = shamt; v.a = a; v.b = b; v.res = res; v.zero = zero; v.ovf = ovf;
      v.lat = lat;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic scramble_inputs();
      req_kind       = 1'($urandom);
      req_invert_a   = 1'($urandom);
      req_invert_b   = 1'($urandom);
      req_operation  = 2'($urandom);
      req_left_right = 1'($urandom);
      req_shamt      = 5'($urandom);
      req_a          = $urandom;
      req_b          = $urandom;
   endtask

   // Issues one request, waits for its response, checks it, optionally holds
   // rsp_ready low for 'hold' cycles with a competing request pending, then retires it.
   task automatic run_vec(input vec_t v, input int hold);
      int  n;
      bit  seen;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_before", {31'd0, req_ready}, 32'd1);
      req_kind       = v.kind;
      req_invert_a   = v.inv_a;
      req_invert_b   = v.inv_b;
      req_operation  = v.op;
      req_left_right = v.lr;
      req_shamt      = v.shamt;
      req_a          = v.a;
      req_b          = v.b;
      req_valid      = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      scramble_inputs();
      // latency = edges from the acceptance edge up to the first edge that samples rsp_valid=1
      n = 0;
      seen = 0;
      while (!seen && n < 60) begin
         @(negedge clk);
         if (rsp_valid) seen = 1;
         else begin
            @(posedge clk);
            n++;
         end
      end
      check("rsp_valid_seen", {31'd0, seen}, 32'd1);
      check("latency", n + 1, v.lat);
      check("result", rsp_result, v.res);
      check("zero", {31'd0, rsp_zero}, {31'd0, v.zero});
      check("overflow", {31'd0, rsp_overflow}, {31'd0, v.ovf});
      check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         @(posedge clk);
         #1;
         check("hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("hold_result", rsp_result, v.res);
         check("hold_flags", {30'd0, rsp_zero, rsp_overflow}, {30'd0, v.zero, v.ovf});
         check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("retire_valid_low", {31'd0, rsp_valid}, 32'd0);
      check("retire_idle", {31'd0, req_ready}, 32'd1);
      check("result_held", rsp_result, v.res);
      req_valid = 1'b0;
   endtask

   vec_t vecs[16];
   bit   stale;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            kind inva invb op    lr   sh     a             b             res           z     o     lat
      vecs[0]  = mk(1'b0,1'b0,1'b1,2'b10,1'b0,5'd0, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 2);
      vecs[1]  = mk(1'b0,1'b0,1'b0,2'b10,1'b0,5'd0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 2);
      vecs[2]  = mk(1'b0,1'b0,1'b1,2'b11,1'b0,5'd0, 32'h80000000, 32'd1,        32'd1,        1'b0, 1'b0, 2);
      vecs[3]  = mk(1'b0,1'b1,1'b1,2'b00,1'b0,5'd0, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 2);
      vecs[4]  = mk(1'b0,1'b0,1'b0,2'b01,1'b0,5'd0, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0, 1'b0, 2);
      vecs[5]  = mk(1'b0,1'b0,1'b0,2'b00,1'b0,5'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0, 2);
      vecs[6]  = mk(1'b0,1'b0,1'b0,2'b10,1'b0,5'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 2);
      vecs[7]  = mk(1'b0,1'b0,1'b0,2'b10,1'b0,5'd0, 32'h80000000, 32'h80000000, 32'd0,        1'b1, 1'b1, 2);
      vecs[8]  = mk(1'b0,1'b0,1'b0,2'b11,1'b0,5'd0, 32'd5,        32'd3,        32'd0,        1'b1, 1'b0, 2);
      vecs[9]  = mk(1'b0,1'b0,1'b1,2'b11,1'b0,5'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 2);
      vecs[10] = mk(1'b1,1'b0,1'b0,2'b10,1'b1,5'd4, 32'h0000000F, 32'h7FFFFFFF, 32'h000000F0, 1'b0, 1'b0, 6);
      vecs[11] = mk(1'b1,1'b0,1'b0,2'b00,1'b0,5'd31,32'h80000000, 32'd0,        32'd1,        1'b0, 1'b0, 33);
      vecs[12] = mk(1'b1,1'b0,1'b0,2'b00,1'b0,5'd0, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0, 1'b0, 2);
      vecs[13] = mk(1'b1,1'b0,1'b0,2'b00,1'b1,5'd31,32'h00000003, 32'd0,        32'h80000000, 1'b0, 1'b0, 33);
      vecs[14] = mk(1'b1,1'b1,1'b1,2'b10,1'b0,5'd8, 32'h12345678, 32'hFFFFFFFF, 32'h00123456, 1'b0, 1'b0, 10);
      vecs[15] = mk(1'b1,1'b0,1'b0,2'b10,1'b1,5'd1, 32'h80000000, 32'h80000000, 32'd0,        1'b1, 1'b0, 3);

      rst_n          = 1'b0;
      req_valid      = 1'b0;
      rsp_ready      = 1'b0;
      req_kind       = 1'b0;
      req_invert_a   = 1'b0;
      req_invert_b   = 1'b0;
      req_operation  = 2'b00;
      req_left_right = 1'b0;
      req_shamt      = 5'd0;
      req_a          = '0;
      req_b          = '0;
      #22;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_req_ready", {31'd0, req_ready}, 32'd1);
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_result", rsp_result, 32'd0);
      check("reset_flags", {30'd0, rsp_zero, rsp_overflow}, 32'd0);

      for (int i = 0; i < 16; i++) run_vec(vecs[i], 0);

      // back-pressure: response held for 10 cycles with a competing request pending
      run_vec(vecs[1], 10);

      // reset in the middle of a 20-bit shift
      @(negedge clk);
      req_kind = 1'b1; req_left_right = 1'b1; req_shamt = 5'd20;
      req_a = 32'hFFFF0000; req_b = '0; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("midrst_result", rsp_result, 32'd0);
      check("midrst_flags", {30'd0, rsp_zero, rsp_overflow}, 32'd0);
      check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      repeat (30) begin
         @(negedge clk);
         if (rsp_valid) stale = 1;
      end
      check("no_stale_response", {31'd0, stale}, 32'd0);
      check("post_reset_idle", {31'd0, req_ready}, 32'd1);
      run_vec(vecs[10], 0);
      run_vec(vecs[2], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_shift_unit.md
ALU_SHIFT_UNIT -- requirements
Module: alu_shift_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port req_valid, input, 1 bit: request present.
REQ-004 SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-005 SHALL have port req_kind, input, 1 bit: 0 selects an ALU request, 1 selects a shift request.
REQ-006 SHALL have port req_invert_a, input, 1 bit: invert operand A before the ALU operation.
REQ-007 SHALL have port req_invert_b, input, 1 bit: invert operand B before the ALU operation; also serves as adder carry-in.
REQ-008 SHALL have port req_operation, input, 2 bits: ALU operation, 00 AND, 01 OR, 10 ADD, 11 SLT.
REQ-009 SHALL have port req_left_right, input, 1 bit: shift direction, 1 left, 0 logical right.
REQ-010 SHALL have port req_shamt, input, 5 bits: shift amount.
REQ-011 SHALL have port req_a, input, 32 bits: ALU operand A, or the shift source.
REQ-012 SHALL have port req_b, input, 32 bits: ALU operand B; ignored for shift requests.
REQ-013 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-014 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-015 SHALL have port rsp_result, output, 32 bits: registered result.
REQ-016 SHALL have port rsp_zero, output, 1 bit: 1 when rsp_result equals 0.
REQ-017 SHALL have port rsp_overflow, output, 1 bit: signed overflow flag for ADD.

Function
REQ-018 SHALL implement FSM states IDLE, ALU, SHIFT and DONE; IDLE is the reset state.
REQ-019 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-020 SHALL latch every request field into internal registers on acceptance; later changes on req_* inputs SHALL have no effect on the accepted request.
REQ-021 SHALL transition IDLE->ALU on acceptance of a request with req_kind=0, and IDLE->SHIFT on acceptance of a request with req_kind=1.
REQ-022 SHALL, in ALU, compute A'=invert_a?~A:A and B'=invert_b?~B:B, then produce: AND: A'&B'; OR: A'|B'; ADD: A'+B'+invert_b, modulo 2^32; SLT: 32'd1 if the signed value A' is less than the signed value B'+invert_b, else 0.
REQ-023 SHALL compute the SLT comparison overflow-correctly, i.e. as the sign of the 33-bit difference, not the raw sum MSB.
REQ-024 SHALL set rsp_overflow=1 for ADD when the carry into bit 31 differs from the carry out of bit 31; it SHALL be 0 for AND, OR, SLT and all shift requests.
REQ-025 SHALL leave ALU for DONE after exactly one cycle, giving a latency of 2 clocks from the acceptance edge to rsp_valid=1.
REQ-026 SHALL, in SHIFT, load a work register with A and a down-counter with shamt, then shift the work register by one bit per cycle, zero-filling, while decrementing the counter.
REQ-027 SHALL move SHIFT->DONE in the cycle where the counter equals 0; latency is shamt+2 clocks, so shamt=0 passes A through unchanged in 2 clocks and shamt=31 takes 33 clocks.
REQ-028 SHALL drive rsp_valid=1 only in DONE; rsp_result, rsp_zero and rsp_overflow SHALL be registered and stay stable while rsp_valid=1 and rsp_ready=0.
REQ-029 SHALL return DONE->IDLE on an edge where rsp_ready=1; a new request SHALL NOT be accepted in that same cycle, so back-to-back throughput is at most one operation per 3 clocks.
REQ-030 SHALL hold rsp_result at its last value when not in DONE; only rsp_valid qualifies it.

Reset
REQ-031 SHALL, on rst_n=0 at any time and independent of clk, force state=IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_overflow=0, clear the counter and work register, and drive req_ready=1 once rst_n=1.
REQ-032 SHALL discard any in-flight operation on reset mid-operation, with no response ever issued for it.

Verification
REQ-033 SHALL pass: ADD, invert_b=1, A=5, B=5 -> result=0, zero=1, overflow=0, rsp_valid 2 clocks after acceptance.
REQ-034 SHALL pass: ADD, A=32'h7FFFFFFF, B=1 -> result=32'h80000000, overflow=1, zero=0.
REQ-035 SHALL pass: SLT, invert_b=1, A=32'h80000000, B=1 -> result=1, overflow=0; NOR (invert_a=1, invert_b=1, AND) with A=B=0 -> result=32'hFFFFFFFF.
REQ-036 SHALL pass: shift left, shamt=4, A=32'h0000000F -> result=32'h000000F0 after 6 clocks; right, shamt=31, A=32'h80000000 -> result=1 after 33 clocks.
REQ-037 SHALL pass: rsp_ready held at 0 for 10 clocks -> rsp_valid, result and flags stable, req_ready=0 throughout.
REQ-038 SHALL pass: rst_n pulsed low mid-SHIFT with shamt=20 -> rsp_valid=0 and all outputs 0 immediately, no stale response afterwards, next request served correctly.
